// File: rtl/exec_ctrl.sv
// exec_ctrl: run/halt/single-step/breakpoint sequencer for the smallScpu core.
// Async pin requests are synchronised and edge-detected, then steer a small
// state machine that gates the CPU clock-enable only on instruction boundaries.
// A retired-instruction counter and the current state are exposed for debug.

module exec_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int BOOT_HOLD   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              run_in,
   input  logic              halt_in,
   input  logic              step_in,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic [ADDR_W-1:0] pc,
   input  logic              instr_done,
   output logic              cpu_en,
   output logic [2:0]        state,
   output logic              break_hit,
   output logic [15:0]       instr_count
);

   // Boot counter only needs to reach BOOT_HOLD-1.
   localparam int BW = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_HOLD - 1);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_HALT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_STEP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // Pin bundle ordering inside the sync pipeline: {step, halt, run}.
   logic [SYNC_STAGES-1:0][2:0] sync_r;
   logic [2:0]                  prev_r;
   logic [2:0]                  pulse_r;

   state_t         state_r;
   state_t         state_s;
   logic           halt_pend_r;
   logic           halt_pend_s;
   logic           bp_skip_r;
   logic           bp_skip_s;
   logic [BW-1:0]  boot_cnt_r;
   logic [BW-1:0]  boot_cnt_s;
   logic [15:0]    count_r;
   logic [15:0]    count_s;

   logic           exec_s;
   logic           done_s;
   logic           bp_match_s;
   logic           run_p_s;
   logic           halt_p_s;
   logic           step_p_s;

   // Synchronise the async pins and register a one-cycle pulse per rising edge.
   // These flops keep sampling even while ena=0 so no stale level lingers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r  <= {SYNC_STAGES{3'b000}};
         prev_r  <= 3'b000;
         pulse_r <= 3'b000;
      end else begin
         sync_r[0] <= {step_in, halt_in, run_in};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         prev_r  <= sync_r[SYNC_STAGES-1];
         pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      end
   end

   // The CPU only executes in RUN or STEP; ena gates it directly so the CPU
   // freezes immediately when the block is deselected.
   assign exec_s     = (state_r == ST_RUN) || (state_r == ST_STEP);
   assign cpu_en     = ena & exec_s;
   assign done_s     = instr_done & cpu_en;
   assign bp_match_s = bp_en & (pc == bp_addr) & ~bp_skip_r;

   // Requests are dropped while the block is frozen.
   assign run_p_s  = pulse_r[0] & ena;
   assign halt_p_s = pulse_r[1] & ena;
   assign step_p_s = pulse_r[2] & ena;

   // Sequencer state register plus its pending flags and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BOOT;
         halt_pend_r <= 1'b0;
         bp_skip_r   <= 1'b0;
         boot_cnt_r  <= {BW{1'b0}};
         count_r     <= 16'h0000;
      end else begin
         state_r     <= state_s;
         halt_pend_r <= halt_pend_s;
         bp_skip_r   <= bp_skip_s;
         boot_cnt_r  <= boot_cnt_s;
         count_r     <= count_s;
      end
   end

   // Next-state logic: transitions happen only on instruction boundaries.
   always_comb begin
      state_s     = state_r;
      halt_pend_s = halt_pend_r;
      bp_skip_s   = bp_skip_r;
      boot_cnt_s  = boot_cnt_r;
      count_s     = count_r;
      if (ena) begin
         // Every accepted retirement counts, including the one ending RUN/STEP,
         // and consumes a pending breakpoint skip.
         if (done_s) begin
            count_s   = count_r + 16'd1;
            bp_skip_s = 1'b0;
         end else begin
            count_s   = count_r;
         end

         case (state_r)
            ST_BOOT: begin
               if (boot_cnt_r == BOOT_LAST) begin
                  state_s    = ST_HALT;
                  boot_cnt_s = {BW{1'b0}};
               end else begin
                  boot_cnt_s = boot_cnt_r + BW'(1'b1);
               end
            end

            ST_HALT: begin
               halt_pend_s = 1'b0;
               if (halt_p_s) begin
                  state_s = ST_HALT;
               end else if (step_p_s) begin
                  state_s = ST_STEP;
               end else if (run_p_s) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_HALT;
               end
            end

            ST_RUN: begin
               // A halt arriving with instr_done applies to that same boundary.
               if (done_s) begin
                  if (bp_match_s) begin
                     state_s     = ST_BREAK;
                     halt_pend_s = 1'b0;
                  end else if (halt_pend_r || halt_p_s) begin
                     state_s     = ST_HALT;
                     halt_pend_s = 1'b0;
                  end else begin
                     state_s     = ST_RUN;
                     halt_pend_s = 1'b0;
                  end
               end else begin
                  halt_pend_s = halt_pend_r | halt_p_s;
               end
            end

            ST_STEP: begin
               halt_pend_s = 1'b0;
               if (done_s) begin
                  state_s = ST_HALT;
               end else begin
                  state_s = ST_STEP;
               end
            end

            ST_BREAK: begin
               // Resuming arms the skip so the same breakpoint cannot re-fire
               // on the very next retirement.
               halt_pend_s = 1'b0;
               if (step_p_s) begin
                  state_s   = ST_STEP;
                  bp_skip_s = 1'b1;
               end else if (run_p_s) begin
                  state_s   = ST_RUN;
                  bp_skip_s = 1'b1;
               end else begin
                  state_s   = ST_BREAK;
               end
            end

            default: begin
               state_s     = ST_BOOT;
               halt_pend_s = 1'b0;
               bp_skip_s   = 1'b0;
               boot_cnt_s  = {BW{1'b0}};
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   assign state       = state_r;
   assign break_hit   = (state_r == ST_BREAK);
   assign instr_count = count_r;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a cycle-level behavioural reference model.

module tb_exec_ctrl;

   localparam int BOOT_HOLD = 4;
   localparam int MS_BOOT = 0, MS_HALT = 1, MS_RUN = 2, MS_STEP = 3, MS_BREAK = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena = 1'b1;
   logic       run_in = 1'b0, halt_in = 1'b0, step_in = 1'b0;
   logic       bp_en = 1'b0;
   logic [7:0] bp_addr = 8'h00;
   logic [7:0] pc = 8'h00;
   logic       instr_done = 1'b0;
   logic       cpu_en;
   logic [2:0] state;
   logic       break_hit;
   logic [15:0] instr_count;

   int total = 0;
   int bad   = 0;

   exec_ctrl #(.ADDR_W(8), .SYNC_STAGES(2), .BOOT_HOLD(BOOT_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .run_in(run_in), .halt_in(halt_in), .step_in(step_in),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr_done(instr_done),
      .cpu_en(cpu_en), .state(state), .break_hit(break_hit),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin history: index i holds the pin sampled (i+1) edges ago. A pin first
   // seen high at edge N takes effect at edge N+3.
   int          m_state = MS_BOOT;
   int          m_boot  = 0;
   bit          m_hp    = 1'b0;
   bit          m_skip  = 1'b0;
   int          m_count = 0;
   logic [3:0]  rh = 4'b0, hh = 4'b0, sh = 4'b0;
   bit          rp, hp, sp, m_en, m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = MS_BOOT; m_boot = 0; m_hp = 1'b0; m_skip = 1'b0; m_count = 0;
         rh = 4'b0; hh = 4'b0; sh = 4'b0;
      end else begin
         rp = rh[2] & ~rh[3];
         hp = hh[2] & ~hh[3];
         sp = sh[2] & ~sh[3];
         rh = {rh[2:0], run_in};
         hh = {hh[2:0], halt_in};
         sh = {sh[2:0], step_in};
         m_en   = ena && (m_state == MS_RUN || m_state == MS_STEP);
         m_done = m_en && instr_done;
         if (ena) begin
            case (m_state)
               MS_BOOT: begin
                  m_boot++;
                  if (m_boot >= BOOT_HOLD) m_state = MS_HALT;
               end
               MS_HALT: if (!hp) begin
                  if (sp) m_state = MS_STEP;
                  else if (rp) m_state = MS_RUN;
               end
               MS_RUN: begin
                  if (hp) m_hp = 1'b1;
                  if (m_done) begin
                     if (bp_en && pc == bp_addr && !m_skip) m_state = MS_BREAK;
                     else if (m_hp) m_state = MS_HALT;
                  end
               end
               MS_STEP: if (m_done) m_state = MS_HALT;
               MS_BREAK: if (sp || rp) begin
                  m_state = sp ? MS_STEP : MS_RUN;
                  m_skip  = 1'b1;
               end
               default: m_state = MS_BOOT;
            endcase
            if (m_done) begin
               m_count = (m_count + 1) % 65536;
               m_skip  = 1'b0;
            end
            if (m_state != MS_RUN) m_hp = 1'b0;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("state", int'(state), m_state);
      chk("cpu_en", int'(cpu_en), int'(ena && (m_state == MS_RUN || m_state == MS_STEP)));
      chk("break_hit", int'(break_hit), int'(m_state == MS_BREAK));
      chk("instr_count", int'(instr_count), m_count);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Single-cycle pin pulse, then wait until it has taken effect.
   task automatic pin_pulse(input logic r, input logic h, input logic s);
      run_in = r; halt_in = h; step_in = s;
      tick(1);
      run_in = 1'b0; halt_in = 1'b0; step_in = 1'b0;
      tick(3);
   endtask

   task automatic do_instr(input logic [7:0] a);
      pc = a;
      instr_done = 1'b1;
      tick(1);
      instr_done = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tick(3);
      chk("rst_state", int'(state), 0);
      chk("rst_cpu_en", int'(cpu_en), 0);
      chk("rst_count", int'(instr_count), 0);
      chk("rst_break", int'(break_hit), 0);
      rst_n = 1'b1;

      // Boot hold then HALT
      tick(3);
      chk("boot_hold", int'(state), 0);
      tick(1);
      chk("boot_to_halt", int'(state), 1);

      // Single step: pin sampled at edge N, cpu_en after edge N+3
      tick(2);
      step_in = 1'b1;
      tick(1);
      step_in = 1'b0;
      tick(2);
      chk("step_not_yet", int'(cpu_en), 0);
      tick(1);
      chk("step_cpu_en", int'(cpu_en), 1);
      chk("step_state", int'(state), 3);
      tick(2);
      do_instr(8'h05);
      chk("step_done_state", int'(state), 1);
      chk("step_done_en", int'(cpu_en), 0);
      chk("step_done_count", int'(instr_count), 1);

      // Breakpoint, skip on resume, re-fire later
      bp_en = 1'b1; bp_addr = 8'h10;
      pin_pulse(1'b1, 1'b0, 1'b0);
      chk("run_entered", int'(state), 2);
      do_instr(8'h03);
      do_instr(8'h10);
      chk("bp_state", int'(state), 4);
      chk("bp_hit", int'(break_hit), 1);
      chk("bp_cpu_en", int'(cpu_en), 0);
      chk("bp_count", int'(instr_count), 3);
      tick(2);
      pin_pulse(1'b1, 1'b0, 1'b0);
      chk("bp_resume", int'(state), 2);
      do_instr(8'h10);
      chk("bp_skip", int'(state), 2);
      chk("bp_skip_count", int'(instr_count), 4);
      do_instr(8'h11);
      do_instr(8'h10);
      chk("bp_refire", int'(state), 4);
      chk("bp_refire_count", int'(instr_count), 6);

      // step beats run in BREAK
      pin_pulse(1'b1, 1'b0, 1'b1);
      chk("break_step_prio", int'(state), 3);
      do_instr(8'h10);
      chk("break_step_done", int'(state), 1);
      chk("break_step_count", int'(instr_count), 7);

      // halt beats run in HALT
      pin_pulse(1'b1, 1'b1, 1'b0);
      chk("halt_prio", int'(state), 1);
      tick(3);
      chk("halt_prio_hold", int'(state), 1);

      // Pending halt waits for instruction boundary
      bp_en = 1'b0;
      pin_pulse(1'b1, 1'b0, 1'b0);
      halt_in = 1'b1;
      tick(1);
      halt_in = 1'b0;
      tick(3);
      tick(4);
      chk("halt_pend_en", int'(cpu_en), 1);
      chk("halt_pend_state", int'(state), 2);
      do_instr(8'h22);
      chk("halt_pend_done", int'(state), 1);
      chk("halt_pend_en_off", int'(cpu_en), 0);
      chk("halt_pend_count", int'(instr_count), 8);

      // Halt pulse coincident with instr_done
      pin_pulse(1'b1, 1'b0, 1'b0);
      halt_in = 1'b1;
      tick(1);
      halt_in = 1'b0;
      tick(2);
      do_instr(8'h23);
      chk("halt_coinc", int'(state), 1);
      chk("halt_coinc_count", int'(instr_count), 9);

      // Reset mid-instruction, then a pulse during BOOT is discarded
      pin_pulse(1'b1, 1'b0, 1'b0);
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("midrst_en", int'(cpu_en), 0);
      chk("midrst_state", int'(state), 0);
      chk("midrst_count", int'(instr_count), 0);
      tick(2);
      rst_n = 1'b1;
      run_in = 1'b1;
      tick(1);
      run_in = 1'b0;
      tick(5);
      chk("boot_pulse_drop", int'(state), 1);

      // Counter wrap
      pin_pulse(1'b1, 1'b0, 1'b0);
      pc = 8'h00;
      instr_done = 1'b1;
      tick(65535);
      chk("count_ffff", int'(instr_count), 65535);
      tick(1);
      chk("count_wrap", int'(instr_count), 0);

      // Freeze: cpu_en drops at once, pulses and retirements ignored
      ena = 1'b0;
      #1;
      chk("ena0_en", int'(cpu_en), 0);
      chk("ena0_state", int'(state), 2);
      halt_in = 1'b1;
      tick(1);
      halt_in = 1'b0;
      tick(5);
      instr_done = 1'b0;
      chk("ena0_count", int'(instr_count), 0);
      chk("ena0_hold", int'(state), 2);
      ena = 1'b1;
      #1;
      chk("ena1_en", int'(cpu_en), 1);
      tick(3);
      chk("ena1_state", int'(state), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
